// File: rtl/data_mem_responder_pkg.sv
// Shared constants and state encoding for the data memory responder.
package data_mem_responder_pkg;

  localparam int DATA_WIDTH = 19;
  localparam int ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

endpackage

// File: rtl/data_mem_responder_mem_array_sp.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module mem_array_sp #(
  parameter int DATA_W     = 19,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Control-bus memory responder: accepts one RD/WR strobe, waits WAIT_CYCLES,
// then answers with a one-cycle READY (plus ERR for illegal requests).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_WIDTH,
  parameter int ADDR_W      = ADDR_WIDTH,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RD_EN,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              READY,
  output logic              BUSY,
  output logic              ERR
);

  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic err_q, err_d;
  logic [DATA_W-1:0] rdata_q;

  logic rd_q, wr_q, ill_q, oor_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic req_in, oor_in, ill_in, accept;
  logic ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata, rdata_mux;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) != '0;
  endfunction

  assign req_in = RD_EN | WR_EN;
  assign oor_in = out_of_range(ADDR);
  assign ill_in = (RD_EN & WR_EN) | oor_in;
  assign accept = (state_q == MEM_IDLE) & req_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEM_IDLE: begin
        if (req_in) begin
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? MEM_RESP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
    // Status outputs are registered copies of where the FSM is heading.
    ready_d = (state_d == MEM_RESP);
    busy_d  = (state_d != MEM_IDLE);
    err_d   = ready_d & (accept ? ill_in : ill_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      if (accept) begin
        rd_q  <= RD_EN & ~WR_EN;
        wr_q  <= WR_EN & ~RD_EN;
        ill_q <= ill_in;
        oor_q <= oor_in;
      end
      if (state_q == MEM_RESP) begin
        rdata_q <= rdata_mux;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= ADDR[DEPTH_LOG2-1:0];
      wdata_q <= WDATA;
    end
  end

  // The RAM reads every cycle; in IDLE it follows ADDR so a zero-wait read
  // lands in RESP, otherwise it tracks the captured address.
  assign ram_addr = (state_q == MEM_IDLE) ? ADDR[DEPTH_LOG2-1:0] : addr_q;
  assign ram_we   = (state_q == MEM_RESP) & wr_q & ~ill_q;

  mem_array_sp #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdata_mux = rdata_q;
    if ((state_q == MEM_RESP) && rd_q) begin
      rdata_mux = oor_q ? '0 : ram_rdata;
    end
  end

  assign RDATA = rdata_mux;
  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states, one with zero wait states.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;

  logic        a_rd, a_wr, a_ready, a_busy, a_err;
  logic [18:0] a_addr, a_wdata, a_rdata;
  logic        z_rd, z_wr, z_ready, z_busy, z_err;
  logic [18:0] z_addr, z_wdata, z_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(19), .ADDR_W(19), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_a (
    .CLK(clk), .RST(rst), .RD_EN(a_rd), .WR_EN(a_wr), .ADDR(a_addr), .WDATA(a_wdata),
    .RDATA(a_rdata), .READY(a_ready), .BUSY(a_busy), .ERR(a_err)
  );

  data_mem_responder #(.DATA_W(19), .ADDR_W(19), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_z (
    .CLK(clk), .RST(rst), .RD_EN(z_rd), .WR_EN(z_wr), .ADDR(z_addr), .WDATA(z_wdata),
    .RDATA(z_rdata), .READY(z_ready), .BUSY(z_busy), .ERR(z_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit z, input logic rd, input logic wr,
                       input logic [18:0] ad, input logic [18:0] wd);
    if (z) begin
      z_rd = rd; z_wr = wr; z_addr = ad; z_wdata = wd;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
    end
  endtask

  task automatic sample(input bit z, output logic rdy, output logic er, output logic [18:0] rd);
    if (z) begin
      rdy = z_ready; er = z_err; rd = z_rdata;
    end else begin
      rdy = a_ready; er = a_err; rd = a_rdata;
    end
  endtask

  // One strobe, then wait (bounded) for READY; lat counts cycles after the strobe cycle.
  task automatic req(input bit z, input logic rd, input logic wr,
                     input logic [18:0] ad, input logic [18:0] wd,
                     output int lat, output logic [18:0] rdata, output logic err);
    logic rdy_s, err_s;
    logic [18:0] rd_s;
    drive(z, rd, wr, ad, wd);
    step();
    drive(z, 1'b0, 1'b0, 19'd0, 19'd0);
    lat = -1; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      sample(z, rdy_s, err_s, rd_s);
      if (rdy_s) begin
        lat = i; rdata = rd_s; err = err_s;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);
    repeat (3) step();
    checks++;
    if ({a_ready, a_busy, a_err, a_rdata} !== 22'd0) begin
      errors++; $display("FAIL reset_hold_a: got %h expected 0", {a_ready, a_busy, a_err, a_rdata});
    end
    checks++;
    if ({z_ready, z_busy, z_err, z_rdata} !== 22'd0) begin
      errors++; $display("FAIL reset_hold_z: got %h expected 0", {z_ready, z_busy, z_err, z_rdata});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({a_ready, a_busy, a_err, a_rdata} !== 22'd0) begin
      errors++; $display("FAIL reset_release_a: got %h expected 0", {a_ready, a_busy, a_err, a_rdata});
    end
    checks++;
    if ({z_ready, z_busy, z_err, z_rdata} !== 22'd0) begin
      errors++; $display("FAIL reset_release_z: got %h expected 0", {z_ready, z_busy, z_err, z_rdata});
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [18:0] rd;
    logic er;
    req(1'b0, 1'b0, 1'b1, 19'd0, 19'h02222, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL wr0: lat=%0d err=%b expected lat=3 err=0", lat, er);
    end
    req(1'b0, 1'b0, 1'b1, 19'd5, 19'h1ABCD, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL wr5: lat=%0d err=%b expected lat=3 err=0", lat, er);
    end
    req(1'b0, 1'b1, 1'b0, 19'd5, 19'd0, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL rd5_timing: lat=%0d err=%b expected lat=3 err=0", lat, er);
    end
    checks++;
    if (rd !== 19'h1ABCD) begin
      errors++; $display("FAIL rd5_data: got %h expected 1abcd", rd);
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [18:0] rd;
    logic er;
    req(1'b0, 1'b1, 1'b1, 19'd5, 19'h07777, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b1) begin
      errors++; $display("FAIL both_strobes: lat=%0d err=%b expected lat=3 err=1", lat, er);
    end
    checks++;
    if (rd !== 19'h1ABCD) begin
      errors++; $display("FAIL both_rdata_held: got %h expected 1abcd", rd);
    end
    req(1'b0, 1'b1, 1'b0, 19'd5, 19'd0, lat, rd, er);
    checks++;
    if (rd !== 19'h1ABCD || er !== 1'b0) begin
      errors++; $display("FAIL both_mem_kept: got %h err=%b expected 1abcd err=0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [18:0] rd;
    logic er;
    req(1'b0, 1'b1, 1'b0, 19'd256, 19'd0, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b1 || rd !== 19'd0) begin
      errors++; $display("FAIL oor_read: lat=%0d err=%b data=%h expected lat=3 err=1 data=0", lat, er, rd);
    end
    req(1'b0, 1'b0, 1'b1, 19'd256, 19'h00007, lat, rd, er);
    checks++;
    if (lat !== 3 || er !== 1'b1) begin
      errors++; $display("FAIL oor_write: lat=%0d err=%b expected lat=3 err=1", lat, er);
    end
    req(1'b0, 1'b1, 1'b0, 19'd0, 19'd0, lat, rd, er);
    checks++;
    if (rd !== 19'h02222 || er !== 1'b0) begin
      errors++; $display("FAIL oor_no_alias: got %h err=%b expected 02222 err=0", rd, er);
    end
  endtask

  task automatic test_busy_ignore();
    int nrdy;
    int ridx;
    logic [18:0] got;
    logic busy_after;
    drive(1'b0, 1'b1, 1'b0, 19'd5, 19'd0);
    step();
    checks++;
    if (a_busy !== 1'b1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL busy_first: busy=%b ready=%b expected busy=1 ready=0", a_busy, a_ready);
    end
    drive(1'b0, 1'b1, 1'b0, 19'd0, 19'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    nrdy = 0; ridx = -1; got = '0; busy_after = 1'bx;
    for (int i = 0; i < 8; i++) begin
      if (a_ready === 1'b1) begin
        nrdy++; got = a_rdata;
        if (ridx < 0) ridx = i;
      end
      if (i == 2) busy_after = a_busy;
      step();
    end
    checks++;
    if (nrdy !== 1 || ridx !== 1) begin
      errors++; $display("FAIL busy_one_ready: count=%0d at=%0d expected count=1 at=1", nrdy, ridx);
    end
    checks++;
    if (got !== 19'h1ABCD) begin
      errors++; $display("FAIL busy_data: got %h expected 1abcd", got);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++; $display("FAIL busy_drop: got %b expected 0", busy_after);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int nrdy;
    logic [18:0] rd;
    logic er;
    req(1'b0, 1'b0, 1'b1, 19'd9, 19'h00333, lat, rd, er);
    drive(1'b0, 1'b0, 1'b1, 19'd9, 19'h55555);
    step();
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %b expected 1", a_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_ready, a_err} !== 3'b000) begin
      errors++; $display("FAIL abort_async: got %b expected 000", {a_busy, a_ready, a_err});
    end
    step();
    rst = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_ready === 1'b1) nrdy++;
      step();
    end
    checks++;
    if (nrdy !== 0) begin
      errors++; $display("FAIL abort_no_ready: count=%0d expected 0", nrdy);
    end
    req(1'b0, 1'b1, 1'b0, 19'd9, 19'd0, lat, rd, er);
    checks++;
    if (rd !== 19'h00333 || er !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL abort_mem_kept: got %h err=%b lat=%0d expected 00333 err=0 lat=3", rd, er, lat);
    end
  endtask

  task automatic test_zero_wait();
    int lat;
    logic [18:0] rd;
    logic er;
    logic [18:0] exp_d;
    req(1'b1, 1'b0, 1'b1, 19'd3, 19'h12345, lat, rd, er);
    checks++;
    if (lat !== 1 || er !== 1'b0) begin
      errors++; $display("FAIL z_write: lat=%0d err=%b expected lat=1 err=0", lat, er);
    end
    req(1'b1, 1'b1, 1'b0, 19'd3, 19'd0, lat, rd, er);
    checks++;
    if (lat !== 1 || rd !== 19'h12345) begin
      errors++; $display("FAIL z_read: lat=%0d data=%h expected lat=1 data=12345", lat, rd);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 19'(10 + i), 19'(19'h00100 + i));
      step();
      drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);
      checks++;
      if (z_ready !== 1'b1 || z_busy !== 1'b1) begin
        errors++; $display("FAIL z_b2b_write%0d: ready=%b busy=%b expected 1 1", i, z_ready, z_busy);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 19'(19'h00100 + i);
      drive(1'b1, 1'b1, 1'b0, 19'(10 + i), 19'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);
      checks++;
      if (z_ready !== 1'b1 || z_rdata !== exp_d) begin
        errors++; $display("FAIL z_b2b_read%0d: ready=%b data=%h expected 1 %h", i, z_ready, z_rdata, exp_d);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    z_rd = 1'b0; z_wr = 1'b0; z_addr = '0; z_wdata = '0;
    test_reset();
    test_write_read();
    test_illegal();
    test_out_of_range();
    test_busy_ignore();
    test_reset_abort();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
